// File: rtl/branch_resolve_btb.sv
// Branch resolution unit with a direct-mapped BTB and saturating direction counters.
// Fetch-side lookup is combinational; EX-side redirect and training are registered.
module branch_resolve_btb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_pc,
  input  logic              res_valid,
  input  logic [3:0]        res_op,
  input  logic [XLEN-1:0]   res_src1,
  input  logic [XLEN-1:0]   res_src2,
  input  logic [XLEN-1:0]   res_offset,
  input  logic [XLEN-1:0]   res_inst_pc,
  input  logic [XLEN-1:0]   res_pred_pc,
  output logic              flush_valid,
  output logic [XLEN-1:0]   flush_pc,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] mispred_cnt
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned TAG_W   = XLEN - IDX_W - 2;

  localparam logic [CNT_W-1:0] CTR_MAX  = '1;
  localparam logic [CNT_W-1:0] CTR_MIN  = '0;
  localparam logic [CNT_W-1:0] CTR_INIT = CNT_W'(1) << (CNT_W - 1);

  localparam logic [3:0] OP_JIRL = 4'd1;
  localparam logic [3:0] OP_B    = 4'd2;
  localparam logic [3:0] OP_BL   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_BLT  = 4'd6;
  localparam logic [3:0] OP_BGE  = 4'd7;
  localparam logic [3:0] OP_BLTU = 4'd8;
  localparam logic [3:0] OP_BGEU = 4'd9;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic               uncond_q [ENTRIES];
  logic [CNT_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;

  logic             is_branch;
  logic             is_uncond;
  logic             taken;
  logic [XLEN-1:0]  tgt;
  logic [XLEN-1:0]  next_pc;
  logic             accepted;
  logic             mispredict;
  logic [CNT_W-1:0] ctr_next;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[XLEN-1:IDX_W+2];
  assign r_idx = res_inst_pc[IDX_W+1:2];
  assign r_tag = res_inst_pc[XLEN-1:IDX_W+2];

  // Fetch lookup sees only pre-edge BTB contents.
  always_comb begin
    f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken = f_hit && (uncond_q[f_idx] || ctr_q[f_idx][CNT_W-1]);
    pred_pc    = pred_taken ? target_q[f_idx] : fetch_pc + XLEN'(4);
  end

  // Branch condition, target and correct next PC for the EX-stage instruction.
  always_comb begin
    is_branch = 1'b0;
    is_uncond = 1'b0;
    taken     = 1'b0;
    unique case (res_op)
      OP_JIRL, OP_B, OP_BL: begin
        is_branch = 1'b1;
        is_uncond = 1'b1;
        taken     = 1'b1;
      end
      OP_BEQ:  begin is_branch = 1'b1; taken = (res_src1 == res_src2); end
      OP_BNE:  begin is_branch = 1'b1; taken = (res_src1 != res_src2); end
      OP_BLT:  begin is_branch = 1'b1; taken = ($signed(res_src1) <  $signed(res_src2)); end
      OP_BGE:  begin is_branch = 1'b1; taken = ($signed(res_src1) >= $signed(res_src2)); end
      OP_BLTU: begin is_branch = 1'b1; taken = (res_src1 <  res_src2); end
      OP_BGEU: begin is_branch = 1'b1; taken = (res_src1 >= res_src2); end
      default: ;
    endcase
    tgt        = ((res_op == OP_JIRL) ? res_src1 : res_inst_pc) + res_offset;
    next_pc    = taken ? tgt : res_inst_pc + XLEN'(4);
    // Anything resolving while a redirect is in flight is on the wrong path.
    accepted   = res_valid && is_branch && !flush_valid;
    mispredict = accepted && (res_pred_pc != next_pc);
    r_hit      = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    if (taken) ctr_next = (ctr_q[r_idx] == CTR_MAX) ? CTR_MAX : ctr_q[r_idx] + CNT_W'(1);
    else       ctr_next = (ctr_q[r_idx] == CTR_MIN) ? CTR_MIN : ctr_q[r_idx] - CNT_W'(1);
  end

  // Redirect, performance counters and BTB valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_valid <= 1'b0;
      flush_pc    <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
      valid_q     <= '0;
    end else begin
      flush_valid <= mispredict;
      if (mispredict) flush_pc    <= next_pc;
      if (accepted)   branch_cnt  <= branch_cnt + PERF_W'(1);
      if (mispredict) mispred_cnt <= mispred_cnt + PERF_W'(1);
      if (accepted && (r_hit || taken)) valid_q[r_idx] <= 1'b1;
    end
  end

  // Entry payload: update on hit, allocate on taken miss, leave alone otherwise.
  always_ff @(posedge clk) begin
    if (!reset && accepted) begin
      if (r_hit) begin
        target_q[r_idx] <= tgt;
        uncond_q[r_idx] <= is_uncond;
        ctr_q[r_idx]    <= ctr_next;
      end else if (taken) begin
        tag_q[r_idx]    <= r_tag;
        target_q[r_idx] <= tgt;
        uncond_q[r_idx] <= is_uncond;
        ctr_q[r_idx]    <= CTR_INIT;
      end
    end
  end

endmodule

// File: doc/branch_resolve_btb.md
Name: branch_resolve_btb

Overview:
- Parametrised branch resolution unit with a direct-mapped branch target buffer (BTB) and 2-bit-style saturating direction counters.
- Fetch side: combinational lookup gives predicted next PC.
- Execute side: resolves branches for the full compare set, raises a registered flush/redirect on mispredict, and trains the BTB.
- Sits between the IF stage (lookup) and the EX stage (resolve); replaces single-cycle combinational branch checking.

Parameters:
- XLEN, 32, datapath/PC width.
- IDX_W, 4, BTB index width; ENTRIES = 2**IDX_W.
- CNT_W, 2, direction counter width (>=2).
- PERF_W, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- fetch_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  BTB predicts taken (combinational).
- pred_pc  out  XLEN  predicted next PC for fetch_pc (combinational).
- res_valid  in  1  EX-stage instruction valid this cycle.
- res_op  in  4  0 none, 1 jirl, 2 b, 3 bl, 4 beq, 5 bne, 6 blt, 7 bge, 8 bltu, 9 bgeu; 10-15 treated as none.
- res_src1  in  XLEN  rj value.
- res_src2  in  XLEN  rd value.
- res_offset  in  XLEN  sign-extended byte offset.
- res_inst_pc  in  XLEN  PC of resolving instruction.
- res_pred_pc  in  XLEN  next PC predicted at fetch time for that instruction.
- flush_valid  out  1  registered redirect pulse.
- flush_pc  out  XLEN  registered correct next PC.
- branch_cnt  out  PERF_W  resolved branches accepted.
- mispred_cnt  out  PERF_W  mispredicts accepted.

Behaviour:
- Reset (synchronous, active-high): all BTB valid bits cleared; flush_valid=0; flush_pc=0; branch_cnt=0; mispred_cnt=0. Tags, targets and counters need no reset.
- BTB entry: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN], uncond bit, ctr[CNT_W]. Index = pc[IDX_W+1:2].
- Lookup (combinational):
  - hit = valid & tag match.
  - pred_taken = hit & (uncond | ctr MSB).
  - pred_pc = pred_taken ? target : fetch_pc+4.
  - Same-cycle write is not visible; lookup reads pre-edge contents.
- Resolve, combinational in the resolve cycle:
  - taken: jirl/b/bl always; beq ==; bne !=; blt/bge signed <, >=; bltu/bgeu unsigned <, >=.
  - tgt = jirl ? src1+offset : inst_pc+offset.
  - next = taken ? tgt : inst_pc+4.
  - Arithmetic is modulo 2^XLEN.
- Accept rule: accepted = res_valid & is_branch & !flush_valid. An instruction resolving in the cycle flush_valid is high is wrong-path: no flush, no training, no count.
- Mispredict = accepted & (res_pred_pc != next).
- Latency 1:
  - On the edge after a mispredict, flush_valid=1 and flush_pc=next for exactly one cycle.
  - Otherwise flush_valid=0 and flush_pc holds its last value.
- Counters: branch_cnt += accepted; mispred_cnt += mispredict. Both wrap modulo 2^PERF_W.
- Training on accepted, at the indexed entry:
  - Tag hit: target <= tgt; uncond <= (op in 1..3); ctr saturating +1 if taken, -1 if not taken (limits 0 and 2^CNT_W-1).
  - Tag miss/invalid, taken: allocate and overwrite with valid=1, tag, target=tgt, uncond, ctr = 2^(CNT_W-1) (weakly taken).
  - Tag miss/invalid, not taken: no write.
- Non-branch or res_op>=10: no flush, no training, no count.
- Reset asserted mid-flush: flush_valid=0 on the next edge; a pending training write in the reset cycle is dropped.

Test Plan:
- Reset, then fetch_pc=0x1C000000 -> pred_taken=0, pred_pc=0x1C000004; counters 0.
- beq at 0x1C000010, src1=src2=5, offset=0x20, res_pred_pc=0x1C000014 -> next cycle flush_valid=1, flush_pc=0x1C000030, mispred_cnt=1; entry allocated with ctr=2; later fetch_pc=0x1C000010 -> pred_pc=0x1C000030.
- Same beq resolved not-taken 3 times (src1=1, src2=2) -> ctr 2→1→0→0 (saturates at 0); pred_pc becomes 0x1C000014 after the first decrement.
- blt with src1=0xFFFFFFFF, src2=1 -> taken (signed); bltu with the same operands -> not taken; flush only where res_pred_pc differs.
- jirl src1=0x1C001000, offset=8, res_pred_pc=0x1C001008 -> no flush, branch_cnt+1, entry uncond=1; next-cycle resolve while flush_valid=1 -> ignored, counters unchanged.
- Aliasing: pc 0x1C000010 and 0x1C000050 (IDX_W=4) -> second taken branch overwrites the entry; lookup of the first misses.
